fetch_control: RTL and testbench
================================

Name: fetch_control

Overview:
- Sequences the program-counter stage.
- Arbitrates PC redirect sources (trap, ROB flush, branch mispredict, decode fix-up) into one PC write.
- Generates stage-0/stage-1 fetch enables from downstream backpressure.
- Runs a refill FSM when fetch leaves the on-chip instruction mapping window: requests the loader, moves the window base, then resumes at the missed PC.

Parameters:
- RESET_PC, 32'h0000_0000: PC written on the first cycle after reset.
- RESET_BASE, 32'h0000_0000: initial mapping window base.
- MAP_BITS, 13: log2 of window size in bytes. Refill address is the PC with bits [MAP_BITS-1:0] cleared.
- HALF_MAP, 0: drives OUT_instrMappingHalfSize (window of 2^(MAP_BITS-1) bytes).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low (0 = reset)
- IN_ready  in  1  decode can accept a fetch bundle
- IN_trapValid / IN_trapPC  in  1/32  trap/interrupt redirect (priority 0, highest)
- IN_flushValid / IN_flushPC  in  1/32  ROB flush redirect (priority 1)
- IN_brValid / IN_brPC  in  1/32  branch mispredict redirect (priority 2)
- IN_decValid / IN_decPC  in  1/32  decode fix-up redirect (priority 3)
- IN_pcRaw  in  32  current fetch PC from the PC stage
- IN_instrMappingMiss  in  1  current PC is outside the window
- OUT_pc  out  32  PC to write into the PC stage
- OUT_write  out  1  PC write strobe
- OUT_en0  out  1  advance PC stage
- OUT_en1  out  1  latch PC-stage outputs
- OUT_instrMappingBase  out  32  window base
- OUT_instrMappingHalfSize  out  1  = HALF_MAP
- OUT_refillReq  out  1  refill request to loader
- OUT_refillAddr  out  32  aligned refill address
- IN_refillAck  in  1  loader accepted request
- IN_refillDone  in  1  window contents valid
- OUT_busy  out  1  FSM not in RUN

Behaviour:
- Reset (rst=0, sampled at posedge):
  - state=RESUME, resumePC=RESET_PC, base=RESET_BASE.
  - OUT_refillReq=0, OUT_en0=0, OUT_en1=0, pending=0, en0Last=0.
  - OUT_write=0 while rst=0. In the first cycle after release, OUT_write=1 and OUT_pc=RESET_PC.
- Redirect arbitration:
  - Fixed priority trap > flush > br > dec. The winner's PC is registered; lower-priority requests in the same cycle are dropped.
  - The winner is emitted the next cycle as OUT_write=1 with OUT_pc = the registered PC (latency 1).
  - A redirect arriving while a registered write is pending overwrites it (newest wins).
  - Redirect PC bit 0 is ignored and forced to 0 on OUT_pc.
- Enables:
  - OUT_en0 = (state==RUN) && IN_ready && !IN_instrMappingMiss && !any redirect valid && !OUT_write.
  - OUT_en1 = en0Last && IN_ready, where en0Last = registered OUT_en0.
  - A redirect or OUT_write forces en0Last=0 next cycle, which squashes the stale stage-1 bundle.
- FSM states RUN, REQ, WAIT, RESUME (2-bit encoding):
  - RUN:
    - Miss with no redirect valid: missPC=IN_pcRaw, go to REQ.
    - Miss with a redirect in the same cycle: the redirect wins, no refill (miss belongs to the wrong path).
  - REQ:
    - OUT_refillReq=1 and OUT_refillAddr={missPC[31:MAP_BITS], 0} are held stable until IN_refillAck.
    - Then go to WAIT. Ack in the same cycle as entry goes to WAIT next cycle.
  - WAIT:
    - On IN_refillDone: base=OUT_refillAddr, go to RESUME.
    - Done without a prior ack is ignored.
  - RESUME:
    - One cycle with OUT_write=1. OUT_pc = pending redirect PC if any, else missPC. Then go to RUN.
- Redirects during REQ/WAIT:
  - Recorded in pending; the highest priority is kept, and a later redirect overwrites an earlier one.
  - The loader transaction is not aborted. The window still moves to missPC's block.
  - The pending PC is written in RESUME. If it misses, RUN re-enters REQ.
- OUT_busy = (state != RUN).
- No combinational path from IN_refill* to OUT_refillReq.

Optional Feature:
- FETCH_CTRL_HALT_EN adds input IN_halt (1) and output OUT_halted (1).
- With the macro defined:
  - IN_halt=1 in RUN forces OUT_en0=0. OUT_halted=1 one cycle after en0Last clears.
  - Redirects are still accepted and written.
  - In REQ/WAIT, the halt is taken after returning to RUN.
- Without the macro: neither port exists and behaviour equals IN_halt=0.

Decomposition:
- Shared package fetch_pkg holds:
  - FetchState_t enum (RUN, REQ, WAIT, RESUME)
  - RedirSrc_t enum (TRAP, FLUSH, BR, DEC)
  - constant REDIR_SRCS=4
- One sub-module, redirect_prio: a combinational 4:1 fixed-priority PC select producing valid, PC and source. It is also reused for the pending-register merge.

Test Plan:
- Reset release, RESET_PC=32'h8000_0000 -> cycle 1 after release: OUT_write=1, OUT_pc=8000_0000. Cycle 2: OUT_en0=IN_ready.
- brValid PC=0x100 and flushValid PC=0x200 in the same cycle -> next cycle one write, OUT_pc=0x200. en1 low for one cycle.
- IN_pcRaw=0x0000_2004 with miss, MAP_BITS=13 -> OUT_refillReq=1 with addr 0x2000 held through 3 cycles of no ack. Ack, then done -> OUT_instrMappingBase=0x2000 and OUT_write with pc 0x2004.
- trapValid PC=0x40 during WAIT -> refill completes, base updated, RESUME writes 0x40, not missPC.
- IN_ready=0 for 5 cycles in RUN -> OUT_en0=OUT_en1=0 throughout. No PC write, no state change.
- rst=0 asserted mid-WAIT -> next cycle OUT_refillReq=0, base=RESET_BASE. After release, write of RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch-control slice: refill FSM states, redirect
// source identifiers and the number of redirect sources.
package fetch_pkg;

  // Number of redirect sources feeding the PC write arbiter.
  localparam int unsigned REDIR_SRCS = 4;

  // Refill sequencer states.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    RESUME = 2'd3
  } FetchState_t;

  // Redirect sources, in descending priority (index 0 wins).
  typedef enum logic [1:0] {
    TRAP  = 2'd0,
    FLUSH = 2'd1,
    BR    = 2'd2,
    DEC   = 2'd3
  } RedirSrc_t;

endpackage

// File: rtl/fetch_control_redirect_prio.sv
// Combinational fixed-priority PC select: the lowest-indexed valid input wins.
// Used both for the incoming redirect sources and for merging a new redirect
// over the pending one.
module redirect_prio
  import fetch_pkg::*;
(
  input  logic [REDIR_SRCS-1:0]       valid_i,
  input  logic [REDIR_SRCS-1:0][31:0] pc_i,
  output logic                        valid_o,
  output logic [31:0]                 pc_o,
  output RedirSrc_t                   src_o
);

  // Scan from lowest priority upward so the highest-priority hit is last written.
  always_comb begin
    valid_o = 1'b0;
    pc_o    = '0;
    src_o   = TRAP;
    for (int i = REDIR_SRCS - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        valid_o = 1'b1;
        pc_o    = pc_i[i];
        src_o   = RedirSrc_t'(i[1:0]);
      end
    end
  end

endmodule

// File: rtl/fetch_control.sv
// Fetch control: PC redirect arbitration, stage-0/1 fetch enables and the
// instruction-mapping refill sequencer.
// Optional feature macro: FETCH_CTRL_HALT_EN adds IN_halt / OUT_halted.
module fetch_control
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] RESET_BASE = 32'h0000_0000,
  parameter int unsigned MAP_BITS   = 13,
  parameter bit          HALF_MAP   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        IN_ready,

  input  logic        IN_trapValid,
  input  logic [31:0] IN_trapPC,
  input  logic        IN_flushValid,
  input  logic [31:0] IN_flushPC,
  input  logic        IN_brValid,
  input  logic [31:0] IN_brPC,
  input  logic        IN_decValid,
  input  logic [31:0] IN_decPC,

  input  logic [31:0] IN_pcRaw,
  input  logic        IN_instrMappingMiss,

  output logic [31:0] OUT_pc,
  output logic        OUT_write,
  output logic        OUT_en0,
  output logic        OUT_en1,

  output logic [31:0] OUT_instrMappingBase,
  output logic        OUT_instrMappingHalfSize,

  output logic        OUT_refillReq,
  output logic [31:0] OUT_refillAddr,
  input  logic        IN_refillAck,
  input  logic        IN_refillDone,

`ifdef FETCH_CTRL_HALT_EN
  input  logic        IN_halt,
  output logic        OUT_halted,
`endif
  output logic        OUT_busy
);

  // Bits cleared from a PC to form its window-block address.
  localparam logic [31:0] MapMask = (32'h1 << MAP_BITS) - 32'h1;

  FetchState_t state_q, state_d;
  logic [31:0] miss_pc_q, miss_pc_d;
  logic [31:0] base_q, base_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        en0_last_q, en0_last_d;

  logic        redir_valid;
  logic [31:0] redir_pc;
  RedirSrc_t   redir_src;

  logic        merge_valid;
  logic [31:0] merge_pc;
  RedirSrc_t   merge_src;

  logic        write_w;
  logic [31:0] pc_w;
  logic        en0_w;
  logic        halt_w;
  logic [31:0] refill_addr;

  // Source identity is not needed downstream; only the PC is forwarded.
  logic unused_src;
  assign unused_src = ^{redir_src, merge_src, merge_valid};

  // ---------------------------------------------------------------------------
  // Redirect arbitration
  // ---------------------------------------------------------------------------

  redirect_prio u_redir_prio (
    .valid_i ({IN_decValid, IN_brValid, IN_flushValid, IN_trapValid}),
    .pc_i    ({IN_decPC, IN_brPC, IN_flushPC, IN_trapPC}),
    .valid_o (redir_valid),
    .pc_o    (redir_pc),
    .src_o   (redir_src)
  );

  // New redirect sits in slot 0 so it always overwrites the pending one.
  redirect_prio u_pend_merge (
    .valid_i ({2'b00, pend_q, redir_valid}),
    .pc_i    ({32'h0, 32'h0, pend_pc_q, redir_pc}),
    .valid_o (merge_valid),
    .pc_o    (merge_pc),
    .src_o   (merge_src)
  );

  // ---------------------------------------------------------------------------
  // Optional halt
  // ---------------------------------------------------------------------------

`ifdef FETCH_CTRL_HALT_EN
  logic halted_q, halted_d;

  assign halt_w = IN_halt;

  // Report halted once the stage-1 pipe has drained while halting in RUN.
  always_comb begin
    halted_d = IN_halt && (state_q == RUN) && !en0_last_q;
  end

  // Halted status register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign OUT_halted = halted_q;
`else
  assign halt_w = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // PC write and enables
  // ---------------------------------------------------------------------------

  assign refill_addr = miss_pc_q & ~MapMask;

  // Select the PC write: registered redirect in RUN, resume target in RESUME.
  always_comb begin
    write_w = 1'b0;
    pc_w    = pend_pc_q;
    unique case (state_q)
      RUN: begin
        write_w = pend_q;
      end
      RESUME: begin
        write_w = 1'b1;
        pc_w    = pend_q ? pend_pc_q : miss_pc_q;
      end
      default: begin
        write_w = 1'b0;
      end
    endcase
  end

  // Stage-0 advances only on a clean RUN cycle with nothing redirecting the PC.
  always_comb begin
    en0_w = rst && (state_q == RUN) && IN_ready && !IN_instrMappingMiss &&
            !redir_valid && !write_w && !halt_w;
  end

  assign OUT_write                = rst && write_w;
  assign OUT_pc                   = {pc_w[31:1], 1'b0};
  assign OUT_en0                  = en0_w;
  assign OUT_en1                  = rst && en0_last_q && IN_ready;
  assign OUT_instrMappingBase     = base_q;
  assign OUT_instrMappingHalfSize = HALF_MAP;
  assign OUT_refillReq            = (state_q == REQ);
  assign OUT_refillAddr           = refill_addr;
  assign OUT_busy                 = (state_q != RUN);

  // ---------------------------------------------------------------------------
  // Refill sequencer and pending redirect
  // ---------------------------------------------------------------------------

  // Next-state logic for the refill FSM, window base and miss PC.
  always_comb begin
    state_d   = state_q;
    miss_pc_d = miss_pc_q;
    base_d    = base_q;
    unique case (state_q)
      RUN: begin
        // A redirect or a PC write in flight means the missing PC is stale.
        if (IN_instrMappingMiss && !redir_valid && !write_w) begin
          miss_pc_d = IN_pcRaw;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (IN_refillAck) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (IN_refillDone) begin
          base_d  = refill_addr;
          state_d = RESUME;
        end
      end
      RESUME: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Pending redirect: newest wins, cleared once it has been written.
  always_comb begin
    pend_pc_d  = merge_pc;
    pend_d     = redir_valid || (pend_q && !OUT_write);
    en0_last_d = en0_w;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RESUME;
      miss_pc_q  <= RESET_PC;
      base_q     <= RESET_BASE;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      en0_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      miss_pc_q  <= miss_pc_d;
      base_q     <= base_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      en0_last_q <= en0_last_d;
    end
  end

endmodule

// File: tb/tb_fetch_control.sv
// Self-checking bench for fetch_control: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a behavioural model.
module tb_fetch_control;

  localparam logic [31:0] RST_PC   = 32'h8000_0000;
  localparam logic [31:0] RST_BASE = 32'h0000_0000;
  localparam int unsigned MAPB     = 13;
  localparam logic [31:0] BLK_MASK = ~((32'h1 << MAPB) - 32'h1);

  localparam int PH_RUN    = 0;
  localparam int PH_REQ    = 1;
  localparam int PH_WAIT   = 2;
  localparam int PH_RESUME = 3;

  logic        clk;
  logic        rst;
  logic        IN_ready;
  logic        IN_trapValid, IN_flushValid, IN_brValid, IN_decValid;
  logic [31:0] IN_trapPC, IN_flushPC, IN_brPC, IN_decPC;
  logic [31:0] IN_pcRaw;
  logic        IN_instrMappingMiss;
  logic [31:0] OUT_pc;
  logic        OUT_write, OUT_en0, OUT_en1;
  logic [31:0] OUT_instrMappingBase;
  logic        OUT_instrMappingHalfSize;
  logic        OUT_refillReq;
  logic [31:0] OUT_refillAddr;
  logic        IN_refillAck, IN_refillDone;
  logic        OUT_busy;
`ifdef FETCH_CTRL_HALT_EN
  logic        IN_halt;
  logic        OUT_halted;
`endif

  fetch_control #(
    .RESET_PC   (RST_PC),
    .RESET_BASE (RST_BASE),
    .MAP_BITS   (MAPB),
    .HALF_MAP   (1'b0)
  ) u_dut (
    .clk                      (clk),
    .rst                      (rst),
    .IN_ready                 (IN_ready),
    .IN_trapValid             (IN_trapValid),
    .IN_trapPC                (IN_trapPC),
    .IN_flushValid            (IN_flushValid),
    .IN_flushPC               (IN_flushPC),
    .IN_brValid               (IN_brValid),
    .IN_brPC                  (IN_brPC),
    .IN_decValid              (IN_decValid),
    .IN_decPC                 (IN_decPC),
    .IN_pcRaw                 (IN_pcRaw),
    .IN_instrMappingMiss      (IN_instrMappingMiss),
    .OUT_pc                   (OUT_pc),
    .OUT_write                (OUT_write),
    .OUT_en0                  (OUT_en0),
    .OUT_en1                  (OUT_en1),
    .OUT_instrMappingBase     (OUT_instrMappingBase),
    .OUT_instrMappingHalfSize (OUT_instrMappingHalfSize),
    .OUT_refillReq            (OUT_refillReq),
    .OUT_refillAddr           (OUT_refillAddr),
    .IN_refillAck             (IN_refillAck),
    .IN_refillDone            (IN_refillDone),
`ifdef FETCH_CTRL_HALT_EN
    .IN_halt                  (IN_halt),
    .OUT_halted               (OUT_halted),
`endif
    .OUT_busy                 (OUT_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Model state, described in terms of the behaviour rather than the RTL.
  int          m_phase;
  logic [31:0] m_miss;
  logic [31:0] m_base;
  bit          m_pend;
  logic [31:0] m_pend_pc;
  bit          m_en0_last;

  // Expected values for the current cycle.
  bit          e_any;
  logic [31:0] e_rpc;
  bit          e_write;
  logic [31:0] e_pc;
  bit          e_en0;
  bit          e_en1;
  bit          e_req;
  logic [31:0] e_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    IN_ready            = 1'b1;
    IN_trapValid        = 1'b0;
    IN_flushValid       = 1'b0;
    IN_brValid          = 1'b0;
    IN_decValid         = 1'b0;
    IN_trapPC           = '0;
    IN_flushPC          = '0;
    IN_brPC             = '0;
    IN_decPC            = '0;
    IN_pcRaw            = '0;
    IN_instrMappingMiss = 1'b0;
    IN_refillAck        = 1'b0;
    IN_refillDone       = 1'b0;
  endtask

  // Derive the expected outputs from model state and present inputs.
  task automatic compute_expect();
    bit          v[4];
    logic [31:0] p[4];
    v[0] = IN_trapValid;  p[0] = IN_trapPC;
    v[1] = IN_flushValid; p[1] = IN_flushPC;
    v[2] = IN_brValid;    p[2] = IN_brPC;
    v[3] = IN_decValid;   p[3] = IN_decPC;
    e_any = 1'b0;
    e_rpc = '0;
    for (int i = 0; i < 4; i++) begin
      if (v[i] && !e_any) begin
        e_any = 1'b1;
        e_rpc = p[i];
      end
    end
    if (!rst) e_write = 1'b0;
    else if (m_phase == PH_RESUME) e_write = 1'b1;
    else if (m_phase == PH_RUN) e_write = m_pend;
    else e_write = 1'b0;
    if (m_phase == PH_RESUME && !m_pend) e_pc = m_miss & 32'hFFFF_FFFE;
    else e_pc = m_pend_pc & 32'hFFFF_FFFE;
    e_en0  = rst && (m_phase == PH_RUN) && IN_ready && !IN_instrMappingMiss && !e_any && !e_write;
    e_en1  = rst && m_en0_last && IN_ready;
    e_req  = (m_phase == PH_REQ);
    e_addr = m_miss & BLK_MASK;
  endtask

  // Compare all observable outputs mid-cycle.
  task automatic sample();
    @(negedge clk);
    compute_expect();
    check_eq("write", {31'b0, OUT_write}, {31'b0, e_write});
    if (e_write) check_eq("pc", OUT_pc, e_pc);
    check_eq("en0", {31'b0, OUT_en0}, {31'b0, e_en0});
    check_eq("en1", {31'b0, OUT_en1}, {31'b0, e_en1});
    check_eq("refill_req", {31'b0, OUT_refillReq}, {31'b0, e_req});
    if (e_req) check_eq("refill_addr", OUT_refillAddr, e_addr);
    check_eq("base", OUT_instrMappingBase, m_base);
    check_eq("busy", {31'b0, OUT_busy}, {31'b0, (m_phase != PH_RUN)});
    check_eq("half", {31'b0, OUT_instrMappingHalfSize}, 32'd0);
  endtask

  // Advance one clock and update the model with what the DUT sampled.
  task automatic step();
    int ph;
    compute_expect();
    @(posedge clk);
    if (!rst) begin
      m_phase    = PH_RESUME;
      m_miss     = RST_PC;
      m_base     = RST_BASE;
      m_pend     = 1'b0;
      m_en0_last = 1'b0;
    end else begin
      ph = m_phase;
      if (ph == PH_RUN && IN_instrMappingMiss && !e_any && !e_write) begin
        m_miss  = IN_pcRaw;
        m_phase = PH_REQ;
      end else if (ph == PH_REQ && IN_refillAck) begin
        m_phase = PH_WAIT;
      end else if (ph == PH_WAIT && IN_refillDone) begin
        m_base  = m_miss & BLK_MASK;
        m_phase = PH_RESUME;
      end else if (ph == PH_RESUME) begin
        m_phase = PH_RUN;
      end
      if (e_any) begin
        m_pend    = 1'b1;
        m_pend_pc = e_rpc;
      end else if (e_write) begin
        m_pend = 1'b0;
      end
      m_en0_last = e_en0;
    end
    #1;
  endtask

  task automatic enter_wait(input logic [31:0] pc);
    IN_pcRaw = pc;
    IN_instrMappingMiss = 1'b1;
    sample(); step();
    IN_instrMappingMiss = 1'b0;
    IN_refillAck = 1'b1;
    sample(); step();
    IN_refillAck = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_phase = PH_RESUME;
    m_miss = RST_PC;
    m_base = RST_BASE;
    m_pend = 1'b0;
    m_pend_pc = '0;
    m_en0_last = 1'b0;
    set_idle();
`ifdef FETCH_CTRL_HALT_EN
    IN_halt = 1'b0;
`endif
    rst = 1'b0;
    step(); step();

    // Reset held, then released.
    sample(); check_eq("rst_write_low", {31'b0, OUT_write}, 32'd0); step();
    rst = 1'b1;
    sample();
    check_eq("rel_write", {31'b0, OUT_write}, 32'd1);
    check_eq("rel_pc", OUT_pc, RST_PC);
    step();
    sample(); check_eq("rel_en0", {31'b0, OUT_en0}, 32'd1); step();

    // Branch and flush together: flush wins, one write.
    IN_brValid = 1'b1; IN_brPC = 32'h100;
    IN_flushValid = 1'b1; IN_flushPC = 32'h200;
    sample(); step();
    set_idle();
    sample();
    check_eq("redir_write", {31'b0, OUT_write}, 32'd1);
    check_eq("redir_pc", OUT_pc, 32'h200);
    check_eq("redir_en1", {31'b0, OUT_en1}, 32'd0);
    step();
    sample(); check_eq("redir_once", {31'b0, OUT_write}, 32'd0); step();

    // Miss at 0x2004: request held without ack, then ack and done.
    IN_pcRaw = 32'h2004; IN_instrMappingMiss = 1'b1;
    sample(); step();
    IN_instrMappingMiss = 1'b0;
    repeat (3) begin
      sample();
      check_eq("hold_req", {31'b0, OUT_refillReq}, 32'd1);
      check_eq("hold_addr", OUT_refillAddr, 32'h2000);
      step();
    end
    IN_refillAck = 1'b1; sample(); step(); IN_refillAck = 1'b0;
    IN_refillDone = 1'b1; sample(); step(); IN_refillDone = 1'b0;
    sample();
    check_eq("refill_base", OUT_instrMappingBase, 32'h2000);
    check_eq("refill_write", {31'b0, OUT_write}, 32'd1);
    check_eq("refill_pc", OUT_pc, 32'h2004);
    step();
    sample(); step();

    // Trap during WAIT wins over the missed PC at resume.
    enter_wait(32'h4008);
    IN_trapValid = 1'b1; IN_trapPC = 32'h40;
    sample(); step();
    IN_trapValid = 1'b0;
    IN_refillDone = 1'b1; sample(); step(); IN_refillDone = 1'b0;
    sample();
    check_eq("trap_base", OUT_instrMappingBase, 32'h4000);
    check_eq("trap_write", {31'b0, OUT_write}, 32'd1);
    check_eq("trap_pc", OUT_pc, 32'h40);
    step();
    sample(); step();

    // Backpressure: nothing moves.
    IN_ready = 1'b0;
    repeat (5) begin
      sample();
      check_eq("bp_en0", {31'b0, OUT_en0}, 32'd0);
      check_eq("bp_en1", {31'b0, OUT_en1}, 32'd0);
      check_eq("bp_write", {31'b0, OUT_write}, 32'd0);
      check_eq("bp_busy", {31'b0, OUT_busy}, 32'd0);
      step();
    end
    IN_ready = 1'b1;

    // Reset asserted mid-WAIT.
    enter_wait(32'h6010);
    rst = 1'b0;
    sample(); step();
    sample();
    check_eq("rstw_req", {31'b0, OUT_refillReq}, 32'd0);
    check_eq("rstw_base", OUT_instrMappingBase, RST_BASE);
    step();
    rst = 1'b1;
    sample();
    check_eq("rstw_write", {31'b0, OUT_write}, 32'd1);
    check_eq("rstw_pc", OUT_pc, RST_PC);
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst                 = ($urandom_range(0, 199) != 0);
      IN_ready            = ($urandom_range(0, 3) != 0);
      IN_instrMappingMiss = ($urandom_range(0, 7) == 0);
      IN_pcRaw            = $urandom;
      IN_trapValid        = ($urandom_range(0, 19) == 0);
      IN_flushValid       = ($urandom_range(0, 14) == 0);
      IN_brValid          = ($urandom_range(0, 11) == 0);
      IN_decValid         = ($urandom_range(0, 11) == 0);
      IN_trapPC           = $urandom;
      IN_flushPC          = $urandom;
      IN_brPC             = $urandom;
      IN_decPC            = $urandom;
      IN_refillAck        = ($urandom_range(0, 2) == 0);
      IN_refillDone       = ($urandom_range(0, 2) == 0);
      sample();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
